// File: rtl/iobuf_bank_turnaround.sv
// Registered bidirectional pad bank with hi-Z turnaround on every direction change.
// Latency: I->IO 1 cycle; IO->O SYNC_STAGES cycles; drive starts TURN_CYCLES+1 edges after T=0.
// Backpressure: none; T changes during a turn are held off until the turn completes.
module iobuf_bank_turnaround #(
    parameter int unsigned          WIDTH       = 8,
    parameter int unsigned          TURN_CYCLES = 1,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]     INIT_OUT    = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             gts_i,
    input  logic             t_i,
    input  logic [WIDTH-1:0] i_i,
    inout  wire  [WIDTH-1:0] io_io,
    output logic [WIDTH-1:0] o_o,
    output logic             valid_o,
    output logic             driving_o
);

    localparam logic [1:0] ST_RX      = 2'd0;
    localparam logic [1:0] ST_TX_TURN = 2'd1;
    localparam logic [1:0] ST_TX      = 2'd2;
    localparam logic [1:0] ST_RX_TURN = 2'd3;

    // Value loaded into the dead-cycle counter when a turn begins.
    localparam logic [3:0] TURN_LOAD = (TURN_CYCLES == 0) ? 4'd0 : 4'(TURN_CYCLES - 1);
    localparam logic [2:0] VALID_SAT = 3'(SYNC_STAGES);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       vcnt_q, vcnt_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // Next-state logic: turns run to completion before T is looked at again.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RX: begin
                if (!t_i) begin
                    state_d = (TURN_CYCLES == 0) ? ST_TX : ST_TX_TURN;
                    cnt_d   = TURN_LOAD;
                end
            end
            ST_TX_TURN: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = ST_TX;
            end
            ST_TX: begin
                if (t_i) begin
                    state_d = (TURN_CYCLES == 0) ? ST_RX : ST_RX_TURN;
                    cnt_d   = TURN_LOAD;
                end
            end
            default: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = ST_RX;
            end
        endcase
    end

    // Settle counter: restarts whenever we are not receiving, saturates once the chain is refilled.
    always_comb begin
        vcnt_d = vcnt_q;
        if (state_q != ST_RX)        vcnt_d = 3'd0;
        else if (vcnt_q < VALID_SAT) vcnt_d = vcnt_q + 3'd1;
    end

    // FSM, counters and output data register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RX;
            cnt_q   <= 4'd0;
            vcnt_q  <= 3'd0;
            out_q   <= INIT_OUT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vcnt_q  <= vcnt_d;
            out_q   <= i_i;
        end
    end

    // Input synchroniser; samples the pads in every state so TX loops back.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= io_io;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Pad enable is combinational so GTS and reset release the bus without a clock.
    assign io_io     = (state_q == ST_TX && !gts_i) ? out_q : {WIDTH{1'bz}};
    assign o_o       = sync_q[SYNC_STAGES-1];
    assign valid_o   = (state_q == ST_RX) && (vcnt_q == VALID_SAT);
    assign driving_o = (state_q == ST_TX);

endmodule

// File: tb/tb_iobuf_bank_turnaround.sv
// Directed bench for the pad bank: one instance with a single dead cycle, one with three.
// Board side is modelled by a tristate driver per bank; it drives only while the DUT should be off.
// A released DUT pad therefore reads back exactly the board pattern.
module tb_iobuf_bank_turnaround;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       gts;
    logic       t1, t3;
    logic [7:0] din;

    logic       drv1_en, drv3_en;
    logic [7:0] drv1_val, drv3_val;
    wire  [7:0] pad1, pad3;

    logic [7:0] o1, o3;
    logic       valid1, valid3, driving1, driving3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign pad1 = drv1_en ? drv1_val : 8'bzzzz_zzzz;
    assign pad3 = drv3_en ? drv3_val : 8'bzzzz_zzzz;

    iobuf_bank_turnaround #(.WIDTH(8), .TURN_CYCLES(1), .SYNC_STAGES(2), .INIT_OUT(8'h5A)) u_dut1 (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .gts_i     (gts),
        .t_i       (t1),
        .i_i       (din),
        .io_io     (pad1),
        .o_o       (o1),
        .valid_o   (valid1),
        .driving_o (driving1)
    );

    iobuf_bank_turnaround #(.WIDTH(8), .TURN_CYCLES(3), .SYNC_STAGES(2), .INIT_OUT(8'h5A)) u_dut3 (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .gts_i     (1'b0),
        .t_i       (t3),
        .i_i       (din),
        .io_io     (pad3),
        .o_o       (o3),
        .valid_o   (valid3),
        .driving_o (driving3)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        gts      = 1'b0;
        t1       = 1'b1;
        t3       = 1'b1;
        din      = 8'hA5;
        drv1_en  = 1'b1;
        drv1_val = 8'h3C;
        drv3_en  = 1'b1;
        drv3_val = 8'h3C;

        // Reset state, board pulling both banks to 3C.
        #3;
        chk("rst_pad1",  pad1, 8'h3C);
        chk("rst_o1",    o1, 8'h00);
        chk("rst_valid", {7'd0, valid1}, 8'd0);
        chk("rst_drv",   {7'd0, driving1}, 8'd0);
        #5;
        rst_n = 1'b1;
        tick();
        chk("settle1_valid", {7'd0, valid1}, 8'd0);
        tick();
        chk("settle2_valid", {7'd0, valid1}, 8'd1);
        chk("settle2_o",     o1, 8'h3C);

        // RX -> TX with one dead cycle.
        t1 = 1'b0;
        tick();
        chk("txturn_pad",   pad1, 8'h3C);
        chk("txturn_drv",   {7'd0, driving1}, 8'd0);
        chk("txturn_valid", {7'd0, valid1}, 8'd0);
        drv1_en = 1'b0;
        tick();
        chk("tx_pad", pad1, 8'hA5);
        chk("tx_drv", {7'd0, driving1}, 8'd1);
        tick();
        tick();
        chk("tx_loopback_o",  o1, 8'hA5);
        chk("tx_loopback_vd", {7'd0, valid1}, 8'd0);

        // TX -> RX: pad released on the first edge seeing T=1, VALID three edges later.
        t1 = 1'b1;
        tick();
        chk("rxturn_drv", {7'd0, driving1}, 8'd0);
        drv1_en  = 1'b1;
        drv1_val = 8'h69;
        #1;
        chk("rxturn_pad", pad1, 8'h69);
        tick();
        chk("rx_n1_valid", {7'd0, valid1}, 8'd0);
        tick();
        chk("rx_n2_valid", {7'd0, valid1}, 8'd0);
        tick();
        chk("rx_n3_valid", {7'd0, valid1}, 8'd1);
        chk("rx_n3_o",     o1, 8'h69);

        // Three dead cycles; T bounced back high mid-turn is ignored.
        t3 = 1'b0;
        tick();
        t3 = 1'b1;
        chk("t3_n0_drv", {7'd0, driving3}, 8'd0);
        tick();
        tick();
        chk("t3_n2_drv", {7'd0, driving3}, 8'd0);
        chk("t3_n2_pad", pad3, 8'h3C);
        drv3_en = 1'b0;
        tick();
        chk("t3_n3_drv", {7'd0, driving3}, 8'd1);
        chk("t3_n3_pad", pad3, 8'hA5);
        tick();
        chk("t3_n4_drv", {7'd0, driving3}, 8'd0);
        drv3_en = 1'b1;
        #1;
        chk("t3_n4_pad", pad3, 8'h3C);

        // Back into TX on bank 1, then one-cycle I->IO latency.
        t1 = 1'b0;
        tick();
        drv1_en = 1'b0;
        tick();
        chk("tx2_pad", pad1, 8'hA5);
        din = 8'hC3;
        #1;
        chk("lat_before_edge", pad1, 8'hA5);
        tick();
        chk("lat_after_edge", pad1, 8'hC3);

        // GTS releases and restores the pads with no clock edge.
        gts      = 1'b1;
        drv1_en  = 1'b1;
        drv1_val = 8'h3C;
        #1;
        chk("gts_pad", pad1, 8'h3C);
        chk("gts_drv", {7'd0, driving1}, 8'd1);
        gts     = 1'b0;
        drv1_en = 1'b0;
        #1;
        chk("gts_off_pad", pad1, 8'hC3);

        // Asynchronous reset while driving.
        tick();
        chk("prerst_drv", {7'd0, driving1}, 8'd1);
        #2;
        rst_n    = 1'b0;
        t1       = 1'b1;
        drv1_en  = 1'b1;
        drv1_val = 8'h96;
        #1;
        chk("arst_pad",   pad1, 8'h96);
        chk("arst_o",     o1, 8'h00);
        chk("arst_drv",   {7'd0, driving1}, 8'd0);
        chk("arst_valid", {7'd0, valid1}, 8'd0);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        chk("postrst_o",     o1, 8'h96);
        chk("postrst_valid", {7'd0, valid1}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
